matmul_tile_sequencer: RTL
==========================

# matmul_tile_sequencer

Job controller between the SPI matrix loader and the matrix-multiply engine. On a `go` request it waits for both operand matrices to be loaded, validates their dimensions, then walks the output matrix C = A·B tile by tile in row-major tile order. For each tile it issues a start pulse with base indices and tile extents to the engine, and waits for the engine's completion. It reports job completion, and reports errors for bad dimensions or operands invalidated mid-job.

## Interface
- `MAX_M`, 784, max rows of A
- `MAX_K`, 288, max cols of A / rows of B
- `MAX_N`, 64, max cols of B
- `TILE_M`, 16, output tile height (≥1, ≤ MAX_M)
- `TILE_N`, 16, output tile width (≥1, ≤ MAX_N)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `go`  in  1  job request; sampled only in IDLE or ERR
- `a_ready`  in  1  matrix A loaded (level, from loader)
- `b_ready`  in  1  matrix B loaded (level, from loader)
- `a_rows`, `a_cols`, `b_rows`, `b_cols`  in  12 each  operand dimensions (loader header fields)
- `eng_start`  out  1  one-cycle tile start pulse
- `eng_row_base`  out  12  first C row of tile
- `eng_col_base`  out  12  first C column of tile
- `eng_tile_m`  out  12  tile rows = min(TILE_M, M − row_base)
- `eng_tile_n`  out  12  tile cols = min(TILE_N, N − col_base)
- `eng_k`  out  12  inner dimension (a_cols)
- `eng_done`  in  1  engine tile-complete pulse
- `busy`  out  1  job in progress
- `done`  out  1  one-cycle job-complete pulse
- `err`  out  1  error level
- `err_code`  out  2  0 none, 1 a_cols≠b_rows, 2 zero/over-max dimension, 3 operand lost

## Operation
- Reset: state IDLE; all outputs 0; internal base/extent registers 0; lost flag 0.
- States:
  - IDLE: if `go`, go to ARM.
  - ARM: wait until `a_ready & b_ready`, then go to CHECK.
  - CHECK: latch M=a_rows, K=a_cols, N=b_cols. Any of M,K,N,b_rows zero, M>MAX_M, K>MAX_K, or N>MAX_N → ERR, code 2. Else a_cols≠b_rows → ERR, code 1. Code 2 has priority. Otherwise row_base=col_base=0 and go to ISSUE.
  - ISSUE: `eng_start`=1 for this cycle only; go to WAIT.
  - WAIT: on `eng_done`, go to ERR with code 3 if the lost flag is set, else go to NEXT.
  - NEXT: if col_base+TILE_N < N, col_base += TILE_N. Else if row_base+TILE_M < M, col_base=0 and row_base += TILE_M. Else go to DONE. Otherwise go to ISSUE.
  - DONE: `done`=1 for one cycle; go to IDLE.
  - ERR: `err` held at 1 and `err_code` held. `go` clears `err` and `err_code` and moves to ARM.
- `eng_*` data outputs are registered. They are valid from the ISSUE cycle and stable until the next ISSUE.
- Tile extents are computed with 13-bit intermediate sums; there is no wrap.
- Lost flag: set when `a_ready` or `b_ready` is low in ISSUE, WAIT or NEXT. The in-flight tile is still allowed to finish. The flag is cleared in CHECK.
- `go` is ignored in ARM through DONE.
- `eng_done` outside WAIT is ignored. This includes `eng_done` in the same cycle as `eng_start`.
- `busy` = 1 in ARM, CHECK, ISSUE, WAIT, NEXT, DONE.
- Reset mid-job: immediate return to reset values. Any later `eng_done` is ignored.

## Timing
- `go` high at edge 0 with both readies high: ARM in cycle 1, CHECK in cycle 2, first `eng_start` in cycle 3.
- Error path: `err` rises in cycle 3; no `eng_start` is issued.
- `eng_done` sampled in cycle c: next `eng_start` in cycle c+2. After the last tile, `done` is high in cycle c+2.
- Tile count per job = ceil(M/TILE_M)·ceil(N/TILE_N).

## Configuration
- `MATMUL_SEQ_PERF_EN` defined: adds outputs `perf_cycles` (out, 32) and `perf_tiles` (out, 16).
  - Both are cleared in CHECK.
  - `perf_cycles` counts every cycle from the first ISSUE through DONE inclusive, saturating at max.
  - `perf_tiles` increments on each accepted `eng_done`.
  - Both hold their values until the next CHECK.
- Not defined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- A 32×288, B 288×64, tile 16×16, engine replies 5 cycles after each start → 8 `eng_start` pulses.
  - Bases in order: (0,0),(0,16),(0,32),(0,48),(16,0),(16,16),(16,32),(16,48).
  - Every tile: `eng_k`=288, extents 16×16.
  - One `done` pulse; `err`=0.
- Ragged: A 20×8, B 8×18 → tiles (0,0) 16×16, (0,16) 16×2, (16,0) 4×16, (16,16) 4×2, then `done`.
- A 4×8, B 9×4 → `err`=1, `err_code`=1 in cycle 3, no `eng_start`. A second `go` with B corrected to 8×4 runs 1 tile (4×4).
- A 0×8 or N=65 → `err_code`=2. A 4×8 with B 9×0 → code 2, not 1.
- `go` with `a_ready`=0, raised 10 cycles later → first `eng_start` 2 cycles after the rise. `go` pulsed in WAIT → no effect.
- A 32×8, B 8×16 (2 tiles); drop `b_ready` during tile 0 WAIT → after `eng_done`, `err_code`=3 and no second start. In a separate run, assert `rst` in WAIT → all outputs 0 at once, and a later `eng_done` causes nothing.

Source files
------------

// File: rtl/matmul_tile_sequencer_if.sv
// Handshake and data bundle between the tile sequencer, the matrix loader and the multiply engine.
interface matmul_tile_sequencer_if;
    logic        go;
    logic        a_ready;
    logic        b_ready;
    logic [11:0] a_rows;
    logic [11:0] a_cols;
    logic [11:0] b_rows;
    logic [11:0] b_cols;
    logic        eng_start;
    logic [11:0] eng_row_base;
    logic [11:0] eng_col_base;
    logic [11:0] eng_tile_m;
    logic [11:0] eng_tile_n;
    logic [11:0] eng_k;
    logic        eng_done;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    modport master (
        input  go, a_ready, b_ready, a_rows, a_cols, b_rows, b_cols, eng_done,
        output eng_start, eng_row_base, eng_col_base, eng_tile_m, eng_tile_n, eng_k,
        output busy, done, err, err_code
    );

    modport slave (
        output go, a_ready, b_ready, a_rows, a_cols, b_rows, b_cols, eng_done,
        input  eng_start, eng_row_base, eng_col_base, eng_tile_m, eng_tile_n, eng_k,
        input  busy, done, err, err_code
    );
endinterface

// File: rtl/matmul_tile_sequencer.sv
// Walks C = A*B tile by tile in row-major order, issuing engine starts and reporting done/errors.
// Optional MATMUL_SEQ_PERF_EN adds perf_cycles/perf_tiles job counters.
module matmul_tile_sequencer #(
    parameter int MAX_M  = 784,
    parameter int MAX_K  = 288,
    parameter int MAX_N  = 64,
    parameter int TILE_M = 16,
    parameter int TILE_N = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    matmul_tile_sequencer_if.master bus
`ifdef MATMUL_SEQ_PERF_EN
    ,
    output logic [31:0]             perf_cycles,
    output logic [15:0]             perf_tiles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_CHECK = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] m_q, m_d, k_q, k_d, n_q, n_d;
    logic [11:0] row_q, row_d, col_q, col_d;
    logic [11:0] tile_m_q, tile_m_d, tile_n_q, tile_n_d, eng_k_q;
    logic        lost_q, lost_d;
    logic [1:0]  code_q, code_d;
    logic        eng_start_q, busy_q, done_q, err_q;
    logic        ready_s, dims_bad_s;
    logic [12:0] row_next_s, col_next_s, row_end_s, col_end_s;

    assign ready_s    = bus.a_ready & bus.b_ready;
    assign dims_bad_s = (bus.a_rows == 12'd0) | (bus.a_cols == 12'd0) |
                        (bus.b_rows == 12'd0) | (bus.b_cols == 12'd0) |
                        (bus.a_rows > 12'(MAX_M)) | (bus.a_cols > 12'(MAX_K)) |
                        (bus.b_cols > 12'(MAX_N));
    assign row_next_s = {1'b0, row_q} + 13'(TILE_M);
    assign col_next_s = {1'b0, col_q} + 13'(TILE_N);

    // Next-state, job dimensions, tile cursor and error bookkeeping
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        k_d     = k_q;
        n_d     = n_q;
        row_d   = row_q;
        col_d   = col_q;
        lost_d  = lost_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE: begin
                if (bus.go) state_d = S_ARM;
                else        state_d = S_IDLE;
            end
            S_ARM: begin
                if (ready_s) state_d = S_CHECK;
                else         state_d = S_ARM;
            end
            S_CHECK: begin
                m_d    = bus.a_rows;
                k_d    = bus.a_cols;
                n_d    = bus.b_cols;
                lost_d = 1'b0;
                if (dims_bad_s) begin
                    state_d = S_ERR;
                    code_d  = 2'd2;
                end else if (bus.a_cols != bus.b_rows) begin
                    state_d = S_ERR;
                    code_d  = 2'd1;
                end else begin
                    row_d   = 12'd0;
                    col_d   = 12'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.eng_done && lost_q) begin
                    state_d = S_ERR;
                    code_d  = 2'd3;
                end else if (bus.eng_done) begin
                    state_d = S_NEXT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_NEXT: begin
                if (col_next_s < {1'b0, n_q}) begin
                    col_d   = col_next_s[11:0];
                    state_d = S_ISSUE;
                end else if (row_next_s < {1'b0, m_q}) begin
                    col_d   = 12'd0;
                    row_d   = row_next_s[11:0];
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            S_ERR: begin
                if (bus.go) begin
                    state_d = S_ARM;
                    code_d  = 2'd0;
                end else begin
                    state_d = S_ERR;
                end
            end
            default: begin
                state_d = S_IDLE;
                code_d  = 2'd0;
            end
        endcase
        // Operand readiness dropping while tiles are in flight poisons the job
        if ((state_q == S_ISSUE || state_q == S_WAIT || state_q == S_NEXT) && !ready_s) begin
            lost_d = 1'b1;
        end else begin
            lost_d = lost_d;
        end
    end

    // Tile extents clipped at the matrix edge using 13-bit sums
    always_comb begin
        row_end_s = {1'b0, row_d} + 13'(TILE_M);
        col_end_s = {1'b0, col_d} + 13'(TILE_N);
        if (row_end_s <= {1'b0, m_d}) tile_m_d = 12'(TILE_M);
        else                          tile_m_d = m_d - row_d;
        if (col_end_s <= {1'b0, n_d}) tile_n_d = 12'(TILE_N);
        else                          tile_n_d = n_d - col_d;
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            m_q         <= 12'd0;
            k_q         <= 12'd0;
            n_q         <= 12'd0;
            row_q       <= 12'd0;
            col_q       <= 12'd0;
            tile_m_q    <= 12'd0;
            tile_n_q    <= 12'd0;
            eng_k_q     <= 12'd0;
            lost_q      <= 1'b0;
            code_q      <= 2'd0;
            eng_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            k_q         <= k_d;
            n_q         <= n_d;
            row_q       <= row_d;
            col_q       <= col_d;
            lost_q      <= lost_d;
            code_q      <= code_d;
            eng_start_q <= (state_d == S_ISSUE);
            busy_q      <= (state_d != S_IDLE) && (state_d != S_ERR);
            done_q      <= (state_d == S_DONE);
            err_q       <= (state_d == S_ERR);
            if (state_d == S_ISSUE) begin
                tile_m_q <= tile_m_d;
                tile_n_q <= tile_n_d;
                eng_k_q  <= k_d;
            end
        end
    end

    assign bus.eng_start    = eng_start_q;
    assign bus.eng_row_base = row_q;
    assign bus.eng_col_base = col_q;
    assign bus.eng_tile_m   = tile_m_q;
    assign bus.eng_tile_n   = tile_n_q;
    assign bus.eng_k        = eng_k_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.err_code     = code_q;

`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0] perf_cycles_q;
    logic [15:0] perf_tiles_q;

    // Job cycle and tile counters, cleared at dimension check
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles_q <= 32'd0;
            perf_tiles_q  <= 16'd0;
        end else if (state_q == S_CHECK) begin
            perf_cycles_q <= 32'd0;
            perf_tiles_q  <= 16'd0;
        end else begin
            if ((state_q == S_ISSUE || state_q == S_WAIT || state_q == S_NEXT ||
                 state_q == S_DONE) && (perf_cycles_q != 32'hFFFF_FFFF)) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if (state_q == S_WAIT && bus.eng_done) begin
                perf_tiles_q <= perf_tiles_q + 16'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_tiles  = perf_tiles_q;
`endif

endmodule
